// File: rtl/dsi_link_sequencer_if.sv
// Control/status bundle between a link controller and dsi_link_sequencer.
// The sequencer side uses the slave modport; the requester side uses master.
interface dsi_link_sequencer_if;
    logic       link_start;
    logic       link_stop;
    logic       err_clear;
    logic [2:0] cfg_lines_number;
    logic       clock_ready;
    logic       lines_ready;
    logic       lines_active;
    logic       clock_enable;
    logic       lines_enable;
    logic       streaming_enable;
    logic [2:0] lines_number;
    logic       link_up;
    logic       link_busy;
    logic       link_error;
    logic [3:0] seq_state;

    modport master (
        output link_start, link_stop, err_clear, cfg_lines_number,
               clock_ready, lines_ready, lines_active,
        input  clock_enable, lines_enable, streaming_enable, lines_number,
               link_up, link_busy, link_error, seq_state
    );

    modport slave (
        input  link_start, link_stop, err_clear, cfg_lines_number,
               clock_ready, lines_ready, lines_active,
        output clock_enable, lines_enable, streaming_enable, lines_number,
               link_up, link_busy, link_error, seq_state
    );
endinterface

// File: rtl/dsi_link_sequencer.sv
// DSI link power sequencer: clock lane -> data lanes -> streaming, reverse on stop.
// Optional DSI_LINK_SEQ_AUTO_RETRY_EN: one automatic re-bring-up after a timeout shutdown.
module dsi_link_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int SETTLE_CYCLES  = 64
) (
    input  logic sys_clk,
    input  logic sys_rst,
    dsi_link_sequencer_if.slave bus
);
    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] CLK_UP     = 4'd1;
    localparam logic [3:0] LANES_UP   = 4'd2;
    localparam logic [3:0] SETTLE     = 4'd3;
    localparam logic [3:0] STREAM     = 4'd4;
    localparam logic [3:0] DRAIN      = 4'd5;
    localparam logic [3:0] LANES_DOWN = 4'd6;
    localparam logic [3:0] CLK_DOWN   = 4'd7;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    logic [3:0]    state, nxt;
    logic [TW-1:0] tmr;
    logic [SW-1:0] stl;
    logic          clock_enable, lines_enable, streaming_enable;
    logic          link_up, link_busy, link_error;
    logic [2:0]    lines_number;
    logic          wait_st, cond_met, tmo, accept, err_set, cfg_ok;
`ifdef DSI_LINK_SEQ_AUTO_RETRY_EN
    logic          retry_pend, retry_used, retry_go;
`endif

    assign cfg_ok = (bus.cfg_lines_number != 3'd0) && (bus.cfg_lines_number <= 3'd4);

    always_comb begin
        wait_st  = 1'b1;
        cond_met = 1'b0;
        case (state)
            CLK_UP:     cond_met = bus.clock_ready;
            LANES_UP:   cond_met = bus.lines_ready;
            DRAIN:      cond_met = !bus.lines_active;
            LANES_DOWN: cond_met = !bus.lines_ready;
            CLK_DOWN:   cond_met = !bus.clock_ready;
            default:    wait_st  = 1'b0;
        endcase
        // Timer reaches TIMEOUT_CYCLES on this edge while still waiting
        tmo     = wait_st && !cond_met && (tmr == TW'(TIMEOUT_CYCLES - 1));
        nxt     = state;
        accept  = 1'b0;
        err_set = tmo;
`ifdef DSI_LINK_SEQ_AUTO_RETRY_EN
        retry_go = 1'b0;
`endif
        case (state)
            IDLE: begin
`ifdef DSI_LINK_SEQ_AUTO_RETRY_EN
                if (retry_pend && !retry_used) begin
                    nxt      = CLK_UP;
                    retry_go = 1'b1;
                end else
`endif
                if (bus.link_start && !bus.link_stop) begin
                    if (cfg_ok) begin
                        nxt    = CLK_UP;
                        accept = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            CLK_UP, LANES_UP, SETTLE: begin
                // Abort unwinds only what has already been enabled
                if (bus.link_stop || tmo)
                    nxt = lines_enable ? DRAIN : CLK_DOWN;
                else if (state == CLK_UP && bus.clock_ready)
                    nxt = LANES_UP;
                else if (state == LANES_UP && bus.lines_ready)
                    nxt = SETTLE;
                else if (state == SETTLE && stl == SW'(SETTLE_CYCLES - 1))
                    nxt = STREAM;
            end
            STREAM:     if (bus.link_stop)  nxt = DRAIN;
            DRAIN:      if (cond_met || tmo) nxt = LANES_DOWN;
            LANES_DOWN: if (cond_met || tmo) nxt = CLK_DOWN;
            CLK_DOWN:   if (cond_met || tmo) nxt = IDLE;
            default:    nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state            <= IDLE;
            tmr              <= '0;
            stl              <= '0;
            clock_enable     <= 1'b0;
            lines_enable     <= 1'b0;
            streaming_enable <= 1'b0;
            link_up          <= 1'b0;
            link_busy        <= 1'b0;
            link_error       <= 1'b0;
            lines_number     <= 3'd1;
`ifdef DSI_LINK_SEQ_AUTO_RETRY_EN
            retry_pend       <= 1'b0;
            retry_used       <= 1'b0;
`endif
        end else begin
            state <= nxt;
            if (nxt != state) begin
                tmr <= '0;
                stl <= '0;
            end else begin
                if (wait_st && tmr != TW'(TIMEOUT_CYCLES)) tmr <= tmr + 1'b1;
                if (state == SETTLE) stl <= stl + 1'b1;
            end

            if (state == IDLE && nxt == CLK_UP)          clock_enable <= 1'b1;
            else if (nxt == CLK_DOWN && state != CLK_DOWN) clock_enable <= 1'b0;

            if (state == CLK_UP && nxt == LANES_UP) lines_enable <= 1'b1;
            else if (nxt == LANES_DOWN)             lines_enable <= 1'b0;

            streaming_enable <= (nxt == STREAM);
            link_up          <= (nxt == STREAM);
            link_busy        <= (nxt != IDLE);

            if (accept) lines_number <= bus.cfg_lines_number;

            // A new error event beats a same-cycle clear
            if (err_set)                       link_error <= 1'b1;
            else if (bus.err_clear || accept)  link_error <= 1'b0;

`ifdef DSI_LINK_SEQ_AUTO_RETRY_EN
            if (tmo)                 retry_pend <= 1'b1;
            else if (state == IDLE)  retry_pend <= 1'b0;
            if (retry_go)                      retry_used <= 1'b1;
            else if (accept || nxt == STREAM)  retry_used <= 1'b0;
`endif
        end
    end

    assign bus.clock_enable     = clock_enable;
    assign bus.lines_enable     = lines_enable;
    assign bus.streaming_enable = streaming_enable;
    assign bus.lines_number     = lines_number;
    assign bus.link_up          = link_up;
    assign bus.link_busy        = link_busy;
    assign bus.link_error       = link_error;
    assign bus.seq_state        = state;
endmodule

// File: tb/tb_dsi_link_sequencer.sv
// Directed bench for dsi_link_sequencer: per-cycle compare against a phase model
// plus hand-computed literal expectations for each scenario.
module tb_dsi_link_sequencer;
    localparam int TO = 16;
    localparam int ST = 4;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    dsi_link_sequencer_if bus();

    dsi_link_sequencer #(.TIMEOUT_CYCLES(TO), .SETTLE_CYCLES(ST)) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Model: phase number, age in phase, and the controls implied by phase changes
    int         m_ph = 0, m_age = 0;
    bit         m_ce, m_le, m_se, m_err, m_pend, m_used;
    logic [2:0] m_ln = 3'd1;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_ph = 0; m_age = 0; m_ce = 0; m_le = 0; m_se = 0; m_err = 0;
            m_ln = 3'd1; m_pend = 0; m_used = 0;
        end else begin
            int np;
            bit waiting, met, to, acc, eset;
            np  = m_ph;
            acc = 0;
            waiting = (m_ph == 1) || (m_ph == 2) || (m_ph >= 5);
            met = (m_ph == 1 && bus.clock_ready) || (m_ph == 2 && bus.lines_ready) ||
                  (m_ph == 5 && !bus.lines_active) || (m_ph == 6 && !bus.lines_ready) ||
                  (m_ph == 7 && !bus.clock_ready);
            to   = waiting && !met && (m_age == TO - 1);
            eset = to;
            if (m_ph == 0) begin
`ifdef DSI_LINK_SEQ_AUTO_RETRY_EN
                if (m_pend && !m_used) begin np = 1; m_used = 1; end else
`endif
                if (bus.link_start && !bus.link_stop) begin
                    if (bus.cfg_lines_number >= 1 && bus.cfg_lines_number <= 4) begin
                        np = 1; acc = 1; m_ln = bus.cfg_lines_number;
                    end else eset = 1;
                end
            end else if (m_ph <= 3) begin
                if (bus.link_stop || to)                   np = m_le ? 5 : 7;
                else if (m_ph == 1 && bus.clock_ready)     np = 2;
                else if (m_ph == 2 && bus.lines_ready)     np = 3;
                else if (m_ph == 3 && m_age == ST - 1)     np = 4;
            end else if (m_ph == 4) begin
                if (bus.link_stop) np = 5;
            end else if (met || to) begin
                np = (m_ph == 7) ? 0 : m_ph + 1;
            end
            if (acc || bus.err_clear) m_err = 0;
            if (eset) m_err = 1;
            if (acc || np == 4) m_used = 0;
            if (to) m_pend = 1; else if (m_ph == 0) m_pend = 0;
            if (m_ph == 0 && np == 1) m_ce = 1;
            if (np == 7 && m_ph != 7) m_ce = 0;
            if (m_ph == 1 && np == 2) m_le = 1;
            if (np == 6) m_le = 0;
            m_se  = (np == 4);
            m_age = (np != m_ph) ? 0 : m_age + 1;
            m_ph  = np;
        end
    end

    always @(negedge sys_clk) begin
        chk("cycle",
            32'({bus.seq_state, bus.clock_enable, bus.lines_enable, bus.streaming_enable,
                 bus.lines_number, bus.link_up, bus.link_busy, bus.link_error}),
            32'({4'(m_ph), m_ce, m_le, m_se, m_ln, (m_ph == 4), (m_ph != 0), m_err}));
    end

    initial begin
        int n;
        bus.link_start = 0; bus.link_stop = 0; bus.err_clear = 0; bus.cfg_lines_number = 3'd4;
        bus.clock_ready = 0; bus.lines_ready = 0; bus.lines_active = 0;
        cyc(2);
        chk("rst_state", 32'(bus.seq_state), 0);
        chk("rst_ln", 32'(bus.lines_number), 1);
        sys_rst = 0;
        cyc(1);

        // Bring-up with 4 lanes
        bus.link_start = 1; cyc(1); bus.link_start = 0;
        chk("up_clk_state", 32'(bus.seq_state), 1);
        chk("up_ce", 32'(bus.clock_enable), 1);
        cyc(2); bus.clock_ready = 1; cyc(1);
        chk("up_lanes_state", 32'(bus.seq_state), 2);
        chk("up_le", 32'(bus.lines_enable), 1);
        chk("up_se_low", 32'(bus.streaming_enable), 0);
        cyc(4); bus.lines_ready = 1; cyc(1);
        chk("settle_state", 32'(bus.seq_state), 3);
        bus.cfg_lines_number = 3'd7;
        n = 0;
        while (!bus.streaming_enable && n < 20) begin cyc(1); n++; end
        chk("settle_len", 32'(n), 4);
        chk("stream_up", 32'(bus.link_up), 1);
        chk("stream_ln", 32'(bus.lines_number), 4);
        bus.lines_active = 1;
        cyc(2);

        // Orderly shutdown
        bus.link_stop = 1; cyc(1); bus.link_stop = 0;
        chk("drain_state", 32'(bus.seq_state), 5);
        chk("drain_se", 32'(bus.streaming_enable), 0);
        cyc(5);
        chk("drain_hold_le", 32'(bus.lines_enable), 1);
        bus.lines_active = 0; cyc(1);
        chk("ldown_le", 32'(bus.lines_enable), 0);
        chk("ldown_state", 32'(bus.seq_state), 6);
        bus.lines_ready = 0; cyc(1);
        chk("cdown_ce", 32'(bus.clock_enable), 0);
        chk("cdown_state", 32'(bus.seq_state), 7);
        bus.clock_ready = 0; cyc(1);
        chk("down_idle", 32'(bus.seq_state), 0);
        chk("down_err", 32'(bus.link_error), 0);

        // Bad lane counts
        bus.cfg_lines_number = 3'd0; bus.link_start = 1; cyc(1); bus.link_start = 0;
        chk("bad0_err", 32'(bus.link_error), 1);
        chk("bad0_state", 32'(bus.seq_state), 0);
        chk("bad0_ce", 32'(bus.clock_enable), 0);
        bus.cfg_lines_number = 3'd5; bus.link_start = 1; bus.err_clear = 1; cyc(1);
        bus.link_start = 0;
        chk("bad5_err_wins", 32'(bus.link_error), 1);
        cyc(1); bus.err_clear = 0;
        chk("err_clear", 32'(bus.link_error), 0);

        // Clock lane never comes up
        bus.cfg_lines_number = 3'd2; bus.link_start = 1; cyc(1); bus.link_start = 0;
        chk("to_clk_state", 32'(bus.seq_state), 1);
        n = 0;
        while (bus.seq_state == 4'd1 && n < 40) begin cyc(1); n++; end
        chk("to_len", 32'(n), TO);
        chk("to_err", 32'(bus.link_error), 1);
        chk("to_ce", 32'(bus.clock_enable), 0);
        chk("to_cdown", 32'(bus.seq_state), 7);
        cyc(1);
        chk("to_idle", 32'(bus.seq_state), 0);
        cyc(1);
`ifdef DSI_LINK_SEQ_AUTO_RETRY_EN
        chk("retry_once", 32'(bus.seq_state), 1);
        cyc(24);
        chk("retry_done", 32'(bus.seq_state), 0);
`else
        chk("no_retry", 32'(bus.seq_state), 0);
`endif
        chk("to_err_sticky", 32'(bus.link_error), 1);
        bus.err_clear = 1; cyc(1); bus.err_clear = 0;

        // start+stop together in IDLE, then abort from LANES_UP
        bus.cfg_lines_number = 3'd3; bus.link_start = 1; bus.link_stop = 1; cyc(1);
        bus.link_stop = 0;
        chk("both_ignored", 32'(bus.seq_state), 0);
        chk("both_no_err", 32'(bus.link_error), 0);
        cyc(1); bus.link_start = 0;
        chk("ab_clk", 32'(bus.seq_state), 1);
        bus.clock_ready = 1; cyc(1);
        chk("ab_lanes", 32'(bus.seq_state), 2);
        bus.link_stop = 1; cyc(1); bus.link_stop = 0;
        chk("ab_drain", 32'(bus.seq_state), 5);
        chk("ab_drain_le", 32'(bus.lines_enable), 1);
        cyc(1);
        chk("ab_ldown", 32'(bus.seq_state), 6);
        cyc(1);
        chk("ab_cdown", 32'(bus.seq_state), 7);
        bus.clock_ready = 0; cyc(1);
        chk("ab_idle", 32'(bus.seq_state), 0);
        chk("ab_ln", 32'(bus.lines_number), 3);

        // Reset while streaming
        bus.cfg_lines_number = 3'd1; bus.link_start = 1; bus.clock_ready = 1; cyc(1);
        bus.link_start = 0; cyc(1);
        bus.cfg_lines_number = 3'd2; bus.lines_ready = 1; cyc(1 + ST);
        chk("pre_rst_stream", 32'(bus.seq_state), 4);
        bus.cfg_lines_number = 3'd3; bus.link_start = 1; cyc(1); bus.link_start = 0;
        chk("stream_ignores_start", 32'(bus.seq_state), 4);
        sys_rst = 1; #1;
        chk("arst_state", 32'(bus.seq_state), 0);
        chk("arst_outs", 32'({bus.clock_enable, bus.lines_enable, bus.streaming_enable,
                              bus.link_up, bus.link_busy, bus.link_error}), 0);
        chk("arst_ln", 32'(bus.lines_number), 1);
        cyc(2);
        sys_rst = 0; bus.clock_ready = 0; bus.lines_ready = 0;
        cyc(3);
        chk("post_rst_idle", 32'(bus.seq_state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/dsi_link_sequencer.md
Name: dsi_link_sequencer

Overview:
- Sequences power-up and power-down of the DSI link in the sys_clk domain: clock lane, then data lanes, then video streaming; reverse order on stop.
- Drives the clock_enable, lines_enable, streaming_enable and lines_number controls of dsi_core.
- Monitors clock_ready, lines_ready and lines_active (already synchronised to sys_clk), with a per-step timeout and sticky error reporting.

Parameters:
- TIMEOUT_CYCLES, 4096: max sys_clk cycles spent waiting in any wait state before a timeout.
- SETTLE_CYCLES, 64: cycles between lines_ready and streaming_enable assertion; must be ≥1.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous reset, active-high
- link_start  in  1  single-cycle request to bring the link up
- link_stop  in  1  single-cycle request to bring the link down
- err_clear  in  1  clears link_error
- cfg_lines_number  in  3  requested lane count, valid 1..4
- clock_ready  in  1  clock lane in HS
- lines_ready  in  1  data lanes out of LP-11 init
- lines_active  in  1  data lanes currently transmitting
- clock_enable  out  1  to dsi_core
- lines_enable  out  1  to dsi_core
- streaming_enable  out  1  to dsi_core
- lines_number  out  3  latched lane count to dsi_core
- link_up  out  1  high while in STREAM
- link_busy  out  1  high in every state except IDLE
- link_error  out  1  sticky: timeout or bad lane count
- seq_state  out  4  current state encoding

Behaviour:
- All outputs are registered. Reset values: all 1-bit outputs 0, lines_number=3'd1, seq_state=IDLE(0).
- States and encodings:
  - IDLE(0); CLK_UP(1); LANES_UP(2); SETTLE(3); STREAM(4); DRAIN(5); LANES_DOWN(6); CLK_DOWN(7).
- IDLE:
  - link_start with cfg_lines_number in 1..4 (sampled cycle N): latch lines_number, clear link_error; clock_enable=1 and state=CLK_UP at N+1.
  - link_start with cfg_lines_number 0 or 5..7: set link_error, stay IDLE, no outputs change.
- CLK_UP: wait clock_ready=1, then lines_enable=1 and go to LANES_UP.
- LANES_UP: wait lines_ready=1, then go to SETTLE.
- SETTLE: count SETTLE_CYCLES, then streaming_enable=1 and go to STREAM.
- STREAM: link_up=1. Stays until link_stop, then streaming_enable=0 and go to DRAIN.
- DRAIN: wait lines_active=0, then lines_enable=0 and go to LANES_DOWN.
- LANES_DOWN: wait lines_ready=0, then clock_enable=0 and go to CLK_DOWN.
- CLK_DOWN: wait clock_ready=0, then go to IDLE.
- link_stop in CLK_UP, LANES_UP or SETTLE aborts bring-up:
  - streaming_enable forced 0; enter DRAIN if lines_enable=1, else CLK_DOWN with clock_enable=0.
- Timeout:
  - A single counter, width $clog2(TIMEOUT_CYCLES+1), is cleared on every state entry and increments in each wait state (CLK_UP, LANES_UP, DRAIN, LANES_DOWN, CLK_DOWN).
  - Reaching TIMEOUT_CYCLES sets link_error.
  - In bring-up states it forces the abort path above.
  - In DRAIN it forces lines_enable=0 and goes to LANES_DOWN; in LANES_DOWN it forces clock_enable=0 and goes to CLK_DOWN; in CLK_DOWN it forces IDLE.
  - The counter saturates; it never wraps.
- Simultaneous events:
  - link_start and link_stop in the same cycle: stop wins; in IDLE both are ignored.
  - link_start outside IDLE: ignored.
  - link_stop in IDLE or in a shutdown state: ignored.
  - err_clear together with a new error event in the same cycle: the error wins, link_error=1.
- cfg_lines_number changes outside IDLE have no effect; lines_number holds its latched value.
- Reset asserted mid-sequence: all outputs return to reset values immediately (asynchronous). No orderly shutdown is attempted.

Optional Feature:
- Macro: DSI_LINK_SEQ_AUTO_RETRY_EN.
- Defined:
  - When a timeout-induced shutdown reaches IDLE, the block re-enters CLK_UP once automatically (clock_enable=1 one cycle after IDLE entry), using the latched lines_number.
  - An internal retry_used flag limits this to one retry. The flag is cleared by an accepted link_start or by reaching STREAM.
  - link_error stays set through the retry.
  - link_stop during the retry cancels it normally.
- Undefined: after a timeout shutdown the block stays in IDLE until the next link_start.

Test Plan:
- TIMEOUT_CYCLES=16, SETTLE_CYCLES=4, cfg_lines_number=4, link_start pulse; model raises clock_ready 3 cycles later, lines_ready 5 cycles after that -> clock_enable, lines_enable, then streaming_enable rise in order; streaming_enable rises exactly 4 cycles after SETTLE entry; link_up=1, lines_number=4.
- From STREAM: link_stop while lines_active=1 for 6 cycles -> streaming_enable=0 next cycle; lines_enable falls 1 cycle after lines_active=0; clock_enable falls after lines_ready=0; IDLE after clock_ready=0; link_error=0.
- cfg_lines_number=0, then 5, each with link_start -> link_error=1, state stays 0, all enables 0; err_clear -> link_error=0.
- clock_ready held 0 after link_start -> link_error=1 after 16 cycles in CLK_UP; clock_enable=0; CLK_DOWN then IDLE.
  - With DSI_LINK_SEQ_AUTO_RETRY_EN: exactly one re-entry to CLK_UP.
- link_start and link_stop in the same cycle in IDLE, then link_stop in LANES_UP -> first pair ignored; abort goes via DRAIN, LANES_DOWN, CLK_DOWN to IDLE.
- sys_rst pulsed while in STREAM -> all outputs 0 asynchronously, seq_state=0, lines_number=1.
